// File: rtl/rs_encoder.sv
// ============================================================================
// Module   : rs_encoder
// Purpose  : Systematic RS(31,27) encoder over GF(2^5), t=2.
//            Field polynomial x^5+x^2+1, alpha = 5'h02.
//            Emits the 27 message symbols unchanged, then 4 parity symbols.
// Ports    : clock, reset_n (async, active-low)
//            in_valid/in_ready/in_data   : message symbol stream (MSB-degree first)
//            out_valid/out_ready/out_data: codeword symbol stream
//            out_sop/out_eop/out_parity  : flags registered alongside out_data
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_encoder (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_data,
  output logic       out_sop,
  output logic       out_eop,
  output logic       out_parity
);

  // Generator g(x) = (x+a)(x+a^2)(x+a^3)(x+a^4), monic, low coefficients.
  localparam logic [4:0] C_G3 = 5'h1E;
  localparam logic [4:0] C_G2 = 5'h06;
  localparam logic [4:0] C_G1 = 5'h09;
  localparam logic [4:0] C_G0 = 5'h11;
  localparam logic [4:0] C_MSG_LAST = 5'd26;
  localparam logic [4:0] C_PAR_LAST = 5'd3;

  typedef enum logic [0:0] {
    ST_MSG = 1'b0,
    ST_PAR = 1'b1
  } state_t;

  // Shift-and-add GF(2^5) multiply; x^5 folds back as x^2+1 (5'h05).
  function automatic logic [4:0] gf_mul(input logic [4:0] a, input logic [4:0] b);
    logic [4:0] acc;
    logic [4:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 5; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[3:0], 1'b0} ^ (sh[4] ? 5'h05 : 5'h00);
    end
    return acc;
  endfunction

  state_t     r_state, w_state_nxt;
  logic [4:0] r_cnt, w_cnt_nxt;
  logic [4:0] r_p3, r_p2, r_p1, r_p0;
  logic [4:0] w_p3_nxt, w_p2_nxt, w_p1_nxt, w_p0_nxt;
  logic       r_run;
  logic       r_out_valid;
  logic [4:0] r_out_data;
  logic       r_out_sop, r_out_eop, r_out_par;

  logic       w_slot_free;
  logic       w_accept;
  logic [4:0] w_fb;
  logic       w_load;
  logic [4:0] w_ld_data;
  logic       w_ld_sop, w_ld_eop, w_ld_par;

  // The output slot can take a new symbol if empty or being drained now.
  assign w_slot_free = !r_out_valid || out_ready;
  // r_run keeps in_ready low while reset is asserted.
  assign in_ready    = r_run && (r_state == ST_MSG) && w_slot_free;
  assign w_accept    = in_valid && in_ready;
  assign w_fb        = in_data ^ r_p3;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_p3_nxt    = r_p3;
    w_p2_nxt    = r_p2;
    w_p1_nxt    = r_p1;
    w_p0_nxt    = r_p0;
    w_load      = 1'b0;
    w_ld_data   = 5'h00;
    w_ld_sop    = 1'b0;
    w_ld_eop    = 1'b0;
    w_ld_par    = 1'b0;
    case (r_state)
      ST_MSG: begin
        if (w_accept) begin
          w_load    = 1'b1;
          w_ld_data = in_data;
          w_ld_sop  = (r_cnt == 5'd0);
          // LFSR division step by g(x).
          w_p3_nxt  = r_p2 ^ gf_mul(w_fb, C_G3);
          w_p2_nxt  = r_p1 ^ gf_mul(w_fb, C_G2);
          w_p1_nxt  = r_p0 ^ gf_mul(w_fb, C_G1);
          w_p0_nxt  = gf_mul(w_fb, C_G0);
          if (r_cnt == C_MSG_LAST) begin
            w_state_nxt = ST_PAR;
            w_cnt_nxt   = 5'd0;
          end else begin
            w_cnt_nxt = r_cnt + 5'd1;
          end
        end
      end
      ST_PAR: begin
        if (w_slot_free) begin
          w_load    = 1'b1;
          w_ld_data = r_p3;
          w_ld_par  = 1'b1;
          w_ld_eop  = (r_cnt == C_PAR_LAST);
          // Shift parity out; zero fill leaves registers clear for next word.
          w_p3_nxt  = r_p2;
          w_p2_nxt  = r_p1;
          w_p1_nxt  = r_p0;
          w_p0_nxt  = 5'h00;
          if (r_cnt == C_PAR_LAST) begin
            w_state_nxt = ST_MSG;
            w_cnt_nxt   = 5'd0;
          end else begin
            w_cnt_nxt = r_cnt + 5'd1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_MSG;
        w_cnt_nxt   = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_MSG;
      r_cnt   <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_run       <= 1'b0;
      r_p3        <= 5'h00;
      r_p2        <= 5'h00;
      r_p1        <= 5'h00;
      r_p0        <= 5'h00;
      r_out_valid <= 1'b0;
      r_out_data  <= 5'h00;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_par   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      r_p3  <= w_p3_nxt;
      r_p2  <= w_p2_nxt;
      r_p1  <= w_p1_nxt;
      r_p0  <= w_p0_nxt;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_ld_data;
        r_out_sop   <= w_ld_sop;
        r_out_eop   <= w_ld_eop;
        r_out_par   <= w_ld_par;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_sop    = r_out_sop;
  assign out_eop    = r_out_eop;
  assign out_parity = r_out_par;

endmodule

`default_nettype wire

// File: tb/tb_rs_encoder.sv
// ============================================================================
// Module   : tb_rs_encoder
// Purpose  : Self-checking bench for rs_encoder. Reference model computes the
//            parity by polynomial long division with a generator built from
//            its roots, using log/antilog field tables.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rs_encoder;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] in_data = 5'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] out_data;
  logic       out_sop, out_eop, out_parity;

  rs_encoder dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_parity (out_parity)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0] d;
    logic       sop;
    logic       par;
    logic       eop;
  } exp_t;

  int         total = 0;
  int         bad = 0;
  int         rdy_low = 0;
  int         consumed = 0;
  logic [4:0] gexp[31];
  int         glog[32];
  logic [4:0] glo[5];
  logic [4:0] tx_q[$];
  logic [4:0] msg_buf[$];
  exp_t       exp_q[$];
  logic [4:0] obs_cw[31];
  logic [4:0] last_cw[31];
  int         obs_idx = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [4:0] gmul(input logic [4:0] a, input logic [4:0] b);
    if (a == 5'h00 || b == 5'h00) return 5'h00;
    return gexp[(glog[a] + glog[b]) % 31];
  endfunction

  task automatic build_field();
    logic [5:0] t;
    gexp[0] = 5'h01;
    glog[1] = 0;
    for (int i = 1; i < 31; i++) begin
      t = {gexp[i-1], 1'b0};
      if (t[5]) t = t ^ 6'h25;
      gexp[i] = t[4:0];
      glog[t[4:0]] = i;
    end
    // g(x) = product over k=1..4 of (x + alpha^k), glo[i] = coeff of x^i
    for (int i = 0; i < 5; i++) glo[i] = 5'h00;
    glo[0] = 5'h01;
    for (int k = 1; k <= 4; k++) begin
      for (int i = 4; i >= 1; i--) glo[i] = glo[i-1] ^ gmul(glo[i], gexp[k]);
      glo[0] = gmul(glo[0], gexp[k]);
    end
  endtask

  // Remainder of m(x)*x^4 divided by g(x); queued as the four parity symbols.
  task automatic finish_msg();
    logic [4:0] w[31];
    logic [4:0] coef;
    exp_t       e;
    for (int i = 0; i < 27; i++) w[i] = msg_buf[i];
    for (int i = 27; i < 31; i++) w[i] = 5'h00;
    for (int i = 0; i < 27; i++) begin
      coef = w[i];
      for (int j = 0; j <= 4; j++) w[i+j] = w[i+j] ^ gmul(coef, glo[4-j]);
    end
    for (int j = 0; j < 4; j++) begin
      e.d = w[27+j]; e.sop = 1'b0; e.par = 1'b1; e.eop = (j == 3);
      exp_q.push_back(e);
    end
    msg_buf.delete();
  endtask

  task automatic check_syndromes();
    logic [4:0] s;
    for (int j = 1; j <= 4; j++) begin
      s = 5'h00;
      for (int i = 0; i < 31; i++) s = gmul(s, gexp[j]) ^ obs_cw[i];
      chk($sformatf("syndrome_a%0d", j), {27'd0, s}, 32'd0);
    end
  endtask

  task automatic cyc(input int vpct, input int rpct);
    exp_t       e;
    logic       f_in, f_out, hold;
    logic [4:0] pd;
    logic       ps, pp, pe;
    in_valid  = (tx_q.size() > 0) && ($urandom_range(0, 99) < vpct);
    in_data   = (tx_q.size() > 0) ? tx_q[0] : 5'h00;
    out_ready = ($urandom_range(0, 99) < rpct);
    #1;
    f_in  = in_valid && in_ready;
    f_out = out_valid && out_ready;
    hold  = out_valid && !out_ready;
    pd = out_data; ps = out_sop; pp = out_parity; pe = out_eop;
    if (!in_ready) rdy_low++;
    if (f_out) begin
      consumed++;
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", {27'd0, out_data}, {27'd0, e.d});
        chk("out_sop", {31'd0, out_sop}, {31'd0, e.sop});
        chk("out_parity", {31'd0, out_parity}, {31'd0, e.par});
        chk("out_eop", {31'd0, out_eop}, {31'd0, e.eop});
        obs_cw[obs_idx] = out_data;
        obs_idx++;
        if (obs_idx == 31) begin
          check_syndromes();
          last_cw = obs_cw;
          obs_idx = 0;
        end
      end
    end
    if (f_in) begin
      e.d = tx_q[0]; e.sop = (msg_buf.size() == 0); e.par = 1'b0; e.eop = 1'b0;
      exp_q.push_back(e);
      msg_buf.push_back(tx_q.pop_front());
      if (msg_buf.size() == 27) finish_msg();
    end
    @(posedge clock);
    #1;
    if (hold) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_data", {27'd0, out_data}, {27'd0, pd});
      chk("hold_flags", {29'd0, out_sop, out_parity, out_eop}, {29'd0, ps, pp, pe});
    end
  endtask

  task automatic drain(input int vpct, input int rpct, input int limit);
    int n;
    n = 0;
    while ((tx_q.size() > 0 || exp_q.size() > 0) && n < limit) begin
      cyc(vpct, rpct);
      n++;
    end
    chk("drain_complete", tx_q.size() + exp_q.size(), 32'd0);
  endtask

  task automatic push_msg(input logic [4:0] last_sym);
    for (int i = 0; i < 26; i++) tx_q.push_back(5'h00);
    tx_q.push_back(last_sym);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_out"}, {27'd0, out_valid, out_sop, out_eop, out_parity, out_data},
        32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
  endtask

  initial begin
    build_field();

    // Reset state
    #3;
    check_outputs_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

    // All-zero message
    push_msg(5'h00);
    drain(100, 100, 60);
    for (int i = 0; i < 31; i++) chk("zero_cw", {27'd0, last_cw[i]}, 32'd0);

    // 26 zeros then 01 : parity is g(x) itself, ready low for 4 cycles
    rdy_low = 0;
    push_msg(5'h01);
    drain(100, 100, 60);
    chk("p_01_0", {27'd0, last_cw[27]}, 32'h1E);
    chk("p_01_1", {27'd0, last_cw[28]}, 32'h06);
    chk("p_01_2", {27'd0, last_cw[29]}, 32'h09);
    chk("p_01_3", {27'd0, last_cw[30]}, 32'h11);
    chk("ready_low_cycles", rdy_low, 32'd4);

    // 26 zeros then alpha
    push_msg(5'h02);
    drain(100, 100, 60);
    chk("p_02_0", {27'd0, last_cw[27]}, 32'h19);
    chk("p_02_1", {27'd0, last_cw[28]}, 32'h0C);
    chk("p_02_2", {27'd0, last_cw[29]}, 32'h12);
    chk("p_02_3", {27'd0, last_cw[30]}, 32'h07);

    // Random messages with valid gaps and output stalls
    for (int m = 0; m < 4; m++)
      for (int i = 0; i < 27; i++) tx_q.push_back(5'($urandom_range(0, 31)));
    drain(70, 60, 3000);

    // Two back-to-back codewords, continuous flow: 62 symbols in 63 cycles
    push_msg(5'h01);
    for (int i = 0; i < 27; i++) tx_q.push_back(5'($urandom_range(0, 31)));
    rdy_low = 0;
    consumed = 0;
    for (int c = 0; c < 63; c++) cyc(100, 100);
    chk("b2b_consumed", consumed, 32'd62);
    chk("b2b_ready_low", rdy_low, 32'd8);
    chk("b2b_queue_empty", exp_q.size(), 32'd0);

    // Reset mid-codeword after 10 accepted symbols
    for (int i = 0; i < 10; i++) tx_q.push_back(5'($urandom_range(0, 31)));
    for (int c = 0; c < 20 && tx_q.size() > 0; c++) cyc(100, 100);
    chk("pre_reset_accepted", msg_buf.size(), 32'd10);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    check_outputs_zero("midreset");
    exp_q.delete();
    msg_buf.delete();
    tx_q.delete();
    obs_idx = 0;
    repeat (2) @(posedge clock);
    #1;
    check_outputs_zero("midreset_held");
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    push_msg(5'h01);
    drain(100, 100, 60);
    chk("rst_p0", {27'd0, last_cw[27]}, 32'h1E);
    chk("rst_p1", {27'd0, last_cw[28]}, 32'h06);
    chk("rst_p2", {27'd0, last_cw[29]}, 32'h09);
    chk("rst_p3", {27'd0, last_cw[30]}, 32'h11);

    // Idle: nothing further may appear
    for (int c = 0; c < 5; c++) cyc(0, 100);
    chk("idle_no_output", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rs_encoder.md
# rs_encoder

Systematic Reed-Solomon RS(31,27) encoder over GF(2^5), t=2. It is the transmit-side counterpart of the RS decoder and uses the same field: primitive polynomial p(x)=x^5+x^2+1, symbol bit i = coefficient of x^i, α=5'h02. The block accepts 27 message symbols on a valid/ready stream and emits a 31-symbol codeword: the 27 message symbols unchanged, then 4 parity symbols. Its output feeds the channel model or test harness that drives the decoder.

## Interface
- Parameters: none. N=31, K=27, the field and the generator g(x) are fixed.
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous reset, active-low; everything runs on one clock, reset is asynchronous and active-low
- in_valid  input  1  in_data holds a message symbol
- in_ready  output  1  encoder accepts a symbol this cycle
- in_data  input  5  message symbol, highest-degree symbol first
- out_valid  output  1  out_data holds a codeword symbol
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  5  codeword symbol
- out_sop  output  1  out_data is codeword symbol 0
- out_eop  output  1  out_data is codeword symbol 30 (last parity)
- out_parity  output  1  out_data is a parity symbol (symbols 27..30)

## Operation
- g(x)=(x+α)(x+α^2)(x+α^3)(x+α^4)=x^4+g3x^3+g2x^2+g1x+g0, with g3=5'h1E, g2=5'h06, g1=5'h09, g0=5'h11. The constant multipliers use the team's GF(2^5) multiplier; addition is 5-bit XOR.
- Parity registers r3..r0, 5 bits each. A symbol is accepted when in_valid && in_ready. On accept: fb=in_data^r3; r3<=r2^fb*g3; r2<=r1^fb*g2; r1<=r0^fb*g1; r0<=fb*g0.
- States:
  - MSG: symbol counter 0..26. in_ready = !out_valid || out_ready. Each accepted symbol loads the output register unchanged. The accept at count 26 moves the block to PAR with the counter reset to 0.
  - PAR: counter 0..3. in_ready=0. In each cycle where the output slot is free (!out_valid || out_ready), out_data<=r3, then r3<=r2, r2<=r1, r1<=r0, r0<=0. The load at count 3 moves the block to MSG with counter 0, and r3..r0 end at 0.
- Output register: out_valid is set on every load. It clears only when out_ready is high and nothing new is loaded that cycle. Flags are registered alongside out_data:
  - out_sop=1 for message count 0.
  - out_parity=1 for every PAR load.
  - out_eop=1 for PAR count 3.
- While out_valid && !out_ready, out_data and the flags hold stable and no state changes.
- The counters wrap only on the transitions above. No partial codewords exist: the block never finishes a codeword early.

## Timing
- Reset (reset_n low, asynchronous): out_valid=0, out_data=0, out_sop=0, out_eop=0, out_parity=0, r3..r0=0, state MSG, counter 0. in_ready is 1 after reset_n goes high, and 0 while reset_n is low.
- Latency: a symbol accepted on edge n appears on out_data after edge n, one cycle latency.
- With out_ready held high and in_valid continuous:
  - message symbols are accepted for 27 cycles;
  - parity p3..p0 follow on the next 4 cycles;
  - in_ready is 0 for exactly those 4 cycles.
  - Codeword period is 31 cycles and the output stream has no bubbles.
- The first parity symbol is presented on the cycle after the last message symbol, provided that slot was consumed.
- If the output is stalled and has not been consumed, loads wait; in_ready is also low in MSG while stalled.
- An in_valid gap in MSG inserts bubbles (out_valid=0) and does not affect the parity.
- A reset_n assertion mid-codeword abandons the codeword. The next accepted symbol is message symbol 0 with out_sop=1.

## Test plan
- All-zero message, 27 × 5'h00, out_ready=1 → 31 symbols of 5'h00; out_sop on symbol 0; out_parity on symbols 27-30; out_eop on symbol 30.
- Message with 26 zeros then 5'h01 → parity 5'h1E, 5'h06, 5'h09, 5'h11; in_ready low for exactly 4 cycles.
- Message with 26 zeros then 5'h02 (α) → parity 5'h19, 5'h0C, 5'h12, 5'h07.
- Random messages with random in_valid gaps and out_ready stalls → every output codeword matches the golden model and gives an all-zero syndrome at α^1..α^4. Each stall holds out_data and the flags stable, and no symbol is dropped or duplicated.
- Two back-to-back codewords with continuous valid/ready → 62 contiguous output symbols, and the second codeword's parity is unaffected by the first (registers cleared).
- reset_n pulsed low after 10 accepted symbols, then the 5'h01-last message sent → all outputs 0 during reset, then parity 5'h1E, 5'h06, 5'h09, 5'h11.
